logic_op_sequencer: RTL

- Upstream feeder and result-capture stage for the 32-bit logic unit (AND/OR/XOR, select f1,f0).
- Accepts a byte stream on a valid/ready interface: one command byte, then operand A as 4 bytes, then operand B as 4 bytes.
- Drives the assembled operands and select lines into the logic unit, registers its combinational result, and presents the result with flags on a valid/ready output interface.

---
 rtl/logic_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/logic_op_sequencer.sv
// Byte-stream feeder for the 32-bit logic unit: gathers a command and two
// operands, drives the unit, captures its result and hands it off downstream.
module logic_op_sequencer #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             lu_f1,
    output logic             lu_f0,
    output logic [W-1:0]     lu_a,
    output logic [W-1:0]     lu_b,
    input  logic [W-1:0]     lu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned BEATS = W / IN_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic             in_ready_d;
    logic [1:0]       op;
    logic             in_fire_c;
    logic             out_fire_c;
    logic             last_beat_c;

    assign in_fire_c   = in_valid && in_ready;
    assign out_fire_c  = out_valid && out_ready;
    assign last_beat_c = (idx == IDX_W'(BEATS - 1));
    assign lu_f1       = op[1];
    assign lu_f0       = op[0];

    // State, beat index and registered in_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_CMD;
            idx      <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            in_ready <= in_ready_d;
        end
    end

    // Next-state and beat index sequencing.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        in_ready_d = 1'b0;
        case (state)
            S_CMD: begin
                if (in_fire_c) begin
                    state_d = S_A;
                    idx_d   = '0;
                end
            end
            S_A: begin
                if (in_fire_c) begin
                    if (last_beat_c) begin
                        state_d = S_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            S_B: begin
                if (in_fire_c) begin
                    if (last_beat_c) begin
                        state_d = S_EXEC;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            S_EXEC: state_d = S_OUT;
            S_OUT: begin
                if (out_fire_c) begin
                    state_d = S_CMD;
                end
            end
            default: begin
                state_d = S_CMD;
                idx_d   = '0;
            end
        endcase
        in_ready_d = (state_d == S_CMD) || (state_d == S_A) || (state_d == S_B);
    end

    // Operand/op capture, result capture and handoff counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op        <= 2'b00;
            lu_a      <= '0;
            lu_b      <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                S_CMD: begin
                    if (in_fire_c) begin
                        op <= in_data[1:0];
                    end
                end
                S_A: begin
                    if (in_fire_c) begin
                        lu_a[int'(idx)*IN_W +: IN_W] <= in_data;
                    end
                end
                S_B: begin
                    if (in_fire_c) begin
                        lu_b[int'(idx)*IN_W +: IN_W] <= in_data;
                    end
                end
                S_EXEC: begin
                    out_data  <= lu_out;
                    out_zero  <= (lu_out == '0);
                    out_err   <= (op == 2'b00);
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_fire_c) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
